// File: rtl/alu_pkg.sv
// Shared types and helpers for the two-requester ALU arbiter.
package alu_pkg;

   localparam int OP_W = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;

   // Opcode layout is {O[1:0], S[2:0]}.
   function automatic logic [1:0] op_o(input logic [OP_W-1:0] op);
      return op[4:3];
   endfunction

   function automatic logic [2:0] op_s(input logic [OP_W-1:0] op);
      return op[2:0];
   endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, otherwise the one not served last.
module alu_rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last,
   output logic grant0,
   output logic grant1
);

   // Grant decode from the current requests and the last-served index.
   always_comb begin
      grant0 = valid0 & (~valid1 | last);
      grant1 = valid1 & (~valid0 | ~last);
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters with round-robin grant.
// Define ALU_CARRY_CHAIN_EN to keep a per-requester carry for multi-word arithmetic.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DW      = 8,
   parameter int ALU_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [OP_W-1:0] req0_op,
   input  logic [DW-1:0]   req0_a,
   input  logic [DW-1:0]   req0_b,
   input  logic            req0_cin,
   input  logic            req0_chain,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [OP_W-1:0] req1_op,
   input  logic [DW-1:0]   req1_a,
   input  logic [DW-1:0]   req1_b,
   input  logic            req1_cin,
   input  logic            req1_chain,
   output logic            rsp0_valid,
   output logic [DW-1:0]   rsp0_f,
   output logic            rsp0_cout,
   output logic            rsp1_valid,
   output logic [DW-1:0]   rsp1_f,
   output logic            rsp1_cout,
   output logic [1:0]      alu_O,
   output logic [2:0]      alu_S,
   output logic [DW-1:0]   alu_A,
   output logic [DW-1:0]   alu_B,
   output logic            alu_C1,
   output logic            alu_G,
   input  logic [DW-1:0]   alu_F,
   input  logic            alu_C2
);

   localparam int               CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                last_q, last_d;
   logic [1:0]          alu_o_q, alu_o_d;
   logic [2:0]          alu_s_q, alu_s_d;
   logic [DW-1:0]       alu_a_q, alu_a_d;
   logic [DW-1:0]       alu_b_q, alu_b_d;
   logic                alu_c1_q, alu_c1_d;
   logic                alu_g_q, alu_g_d;
   logic [1:0]          rsp_valid_q, rsp_valid_d;
   logic [1:0][DW-1:0]  rsp_f_q, rsp_f_d;
   logic [1:0]          rsp_cout_q, rsp_cout_d;

   logic                grant0, grant1;
   logic                c1_0, c1_1;
   logic [OP_W-1:0]     sel_op;
   logic [DW-1:0]       sel_a, sel_b;
   logic                sel_c1;

`ifdef ALU_CARRY_CHAIN_EN
   logic [1:0]          cy_q, cy_d;
   assign c1_0 = req0_chain ? cy_q[0] : req0_cin;
   assign c1_1 = req1_chain ? cy_q[1] : req1_cin;
`else
   logic                unused_chain;
   assign unused_chain = req0_chain ^ req1_chain;
   assign c1_0 = req0_cin;
   assign c1_1 = req1_cin;
`endif

   alu_rr_arb2 u_arb (
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .last   (last_q),
      .grant0 (grant0),
      .grant1 (grant1)
   );

   assign req0_ready = (state_q == ST_IDLE) & grant0;
   assign req1_ready = (state_q == ST_IDLE) & grant1;

   // Next-state logic: accept in IDLE, count down the ALU latency in EXEC, then capture.
   always_comb begin
      sel_op      = grant1 ? req1_op : req0_op;
      sel_a       = grant1 ? req1_a  : req0_a;
      sel_b       = grant1 ? req1_b  : req0_b;
      sel_c1      = grant1 ? c1_1    : c1_0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      alu_o_d     = alu_o_q;
      alu_s_d     = alu_s_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_c1_d    = alu_c1_q;
      alu_g_d     = alu_g_q;
      rsp_valid_d = 2'b00;
      rsp_f_d     = rsp_f_q;
      rsp_cout_d  = rsp_cout_q;
`ifdef ALU_CARRY_CHAIN_EN
      cy_d        = cy_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant0 || grant1) begin
               state_d  = ST_EXEC;
               cnt_d    = CNT_INIT;
               last_d   = grant1;
               alu_o_d  = op_o(sel_op);
               alu_s_d  = op_s(sel_op);
               alu_a_d  = sel_a;
               alu_b_d  = sel_b;
               alu_c1_d = sel_c1;
               alu_g_d  = 1'b1;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (cnt_q != CNT_ZERO) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               // last_q already names the requester that owns the in-flight op.
               rsp_valid_d[last_q] = 1'b1;
               rsp_f_d[last_q]     = alu_F;
               rsp_cout_d[last_q]  = alu_C2;
`ifdef ALU_CARRY_CHAIN_EN
               cy_d[last_q]        = alu_C2;
`endif
               alu_g_d             = 1'b0;
               state_d             = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            alu_g_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= CNT_ZERO;
         last_q      <= 1'b1;
         alu_o_q     <= 2'b00;
         alu_s_q     <= 3'b000;
         alu_a_q     <= {DW{1'b0}};
         alu_b_q     <= {DW{1'b0}};
         alu_c1_q    <= 1'b0;
         alu_g_q     <= 1'b0;
         rsp_valid_q <= 2'b00;
         rsp_f_q     <= {(2*DW){1'b0}};
         rsp_cout_q  <= 2'b00;
`ifdef ALU_CARRY_CHAIN_EN
         cy_q        <= 2'b00;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         alu_o_q     <= alu_o_d;
         alu_s_q     <= alu_s_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_c1_q    <= alu_c1_d;
         alu_g_q     <= alu_g_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_f_q     <= rsp_f_d;
         rsp_cout_q  <= rsp_cout_d;
`ifdef ALU_CARRY_CHAIN_EN
         cy_q        <= cy_d;
`endif
      end
   end

   assign alu_O      = alu_o_q;
   assign alu_S      = alu_s_q;
   assign alu_A      = alu_a_q;
   assign alu_B      = alu_b_q;
   assign alu_C1     = alu_c1_q;
   assign alu_G      = alu_g_q;
   assign rsp0_valid = rsp_valid_q[0];
   assign rsp1_valid = rsp_valid_q[1];
   assign rsp0_f     = rsp_f_q[0];
   assign rsp1_f     = rsp_f_q[1];
   assign rsp0_cout  = rsp_cout_q[0];
   assign rsp1_cout  = rsp_cout_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised bench for alu_arbiter: a timestamp-based transaction model predicts every
// output each cycle; directed sequences pin the model with hand-computed results.
module tb_alu_arbiter;

   localparam int DW  = 8;
   localparam int LAT = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      v = 2'b00;
   logic [1:0][4:0] op = '0;
   logic [1:0][7:0] a = '0;
   logic [1:0][7:0] b = '0;
   logic [1:0]      cin = 2'b00;
   logic [1:0]      chain = 2'b00;
   logic [1:0]      rdy, r_v, r_c;
   logic [1:0][7:0] r_f;
   logic [1:0]      alu_O;
   logic [2:0]      alu_S;
   logic [7:0]      alu_A, alu_B, alu_F;
   logic            alu_C1, alu_G, alu_C2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Bench ALU: S selects add/sub/and/or/xor/pass; result is {carry, F}.
   function automatic logic [8:0] alu_fn(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y,
                                         input logic ci);
      logic [8:0] r;
      case (o[2:0])
         3'd0:    r = {1'b0, x} + {1'b0, y} + {8'd0, ci};
         3'd1:    r = {1'b0, x} + {1'b0, ~y} + {8'd0, ci};
         3'd2:    r = {1'b0, x & y};
         3'd3:    r = {1'b0, x | y};
         3'd4:    r = {1'b0, x ^ y};
         default: r = {1'b0, x};
      endcase
      return r;
   endfunction

   assign {alu_C2, alu_F} = alu_fn({alu_O, alu_S}, alu_A, alu_B, alu_C1);

   alu_arbiter #(.DW(DW), .ALU_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(v[0]), .req0_ready(rdy[0]), .req0_op(op[0]), .req0_a(a[0]), .req0_b(b[0]),
      .req0_cin(cin[0]), .req0_chain(chain[0]),
      .req1_valid(v[1]), .req1_ready(rdy[1]), .req1_op(op[1]), .req1_a(a[1]), .req1_b(b[1]),
      .req1_cin(cin[1]), .req1_chain(chain[1]),
      .rsp0_valid(r_v[0]), .rsp0_f(r_f[0]), .rsp0_cout(r_c[0]),
      .rsp1_valid(r_v[1]), .rsp1_f(r_f[1]), .rsp1_cout(r_c[1]),
      .alu_O(alu_O), .alu_S(alu_S), .alu_A(alu_A), .alu_B(alu_B), .alu_C1(alu_C1), .alu_G(alu_G),
      .alu_F(alu_F), .alu_C2(alu_C2)
   );

   // Model state: the arbiter is busy until cycle free_at; one op may be pending.
   int              cyc = 0;
   int              free_at = 0;
   logic            m_last = 1'b1;
   logic [1:0]      m_rv = 2'b00, m_acc = 2'b00, m_c = 2'b00, m_cy = 2'b00;
   logic [1:0][7:0] m_f = '0;
   logic [1:0]      m_o = 2'b00;
   logic [2:0]      m_s = 3'b000;
   logic [7:0]      m_a = 8'h00, m_b = 8'h00;
   logic            m_c1 = 1'b0;
   bit              p_val = 1'b0;
   int              p_n = 0, p_due = 0;
   logic [8:0]      p_res = 9'h000;
   bit              chk_en = 1'b0, cap_en = 1'b0;
   int              gq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit m_ready(input int n);
      if (cyc < free_at || !v[n]) return 1'b0;
      if (!v[1-n]) return 1'b1;
      return (n != int'(m_last));
   endfunction

   // Model update at each rising edge, driven only by bench-side inputs.
   always @(posedge clk) begin
      logic [1:0] acc;
      logic       c1;
      acc  = 2'b00;
      m_rv = 2'b00;
      if (rst) begin
         free_at = 0; m_last = 1'b1; p_val = 1'b0;
         m_f = '0; m_c = 2'b00; m_cy = 2'b00;
         m_o = 2'b00; m_s = 3'b000; m_a = 8'h00; m_b = 8'h00; m_c1 = 1'b0;
         chk_en = 1'b1;
      end else begin
         if (p_val && p_due == cyc + 1) begin
            m_rv[p_n] = 1'b1;
            m_f[p_n]  = p_res[7:0];
            m_c[p_n]  = p_res[8];
            m_cy[p_n] = p_res[8];
            p_val     = 1'b0;
         end
         acc = {m_ready(1), m_ready(0)};
         for (int n = 0; n < 2; n++) begin
            if (acc[n]) begin
`ifdef ALU_CARRY_CHAIN_EN
               c1 = chain[n] ? m_cy[n] : cin[n];
`else
               c1 = cin[n];
`endif
               m_last  = (n == 1);
               free_at = cyc + 1 + LAT;
               m_o = op[n][4:3]; m_s = op[n][2:0]; m_a = a[n]; m_b = b[n]; m_c1 = c1;
               p_res = alu_fn(op[n], a[n], b[n], c1);
               p_val = 1'b1; p_n = n; p_due = cyc + 1 + LAT;
            end
         end
      end
      m_acc = acc;
      cyc++;
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int n = 0; n < 2; n++) begin
            chk($sformatf("ready%0d", n), 32'(rdy[n]), 32'(m_ready(n)));
            chk($sformatf("rsp%0d_valid", n), 32'(r_v[n]), 32'(m_rv[n]));
            chk($sformatf("rsp%0d_f", n), 32'(r_f[n]), 32'(m_f[n]));
            chk($sformatf("rsp%0d_cout", n), 32'(r_c[n]), 32'(m_c[n]));
         end
         chk("alu_G", 32'(alu_G), 32'(cyc < free_at));
         chk("alu_O", 32'(alu_O), 32'(m_o));
         chk("alu_S", 32'(alu_S), 32'(m_s));
         chk("alu_A", 32'(alu_A), 32'(m_a));
         chk("alu_B", 32'(alu_B), 32'(m_b));
         chk("alu_C1", 32'(alu_C1), 32'(m_c1));
         chk("rsp_overlap", 32'(r_v[0] & r_v[1]), 32'd0);
         if (cap_en) begin
            for (int n = 0; n < 2; n++) if (rdy[n] && v[n]) gq.push_back(n);
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(rdy), 32'd0);
      chk("rst_alu_G", 32'(alu_G), 32'd0);
      chk("rst_rsp_valid", 32'(r_v), 32'd0);
      chk("rst_rsp_f", 32'(r_f), 32'd0);
      chk("rst_alu_A", 32'(alu_A), 32'd0);
   endtask

   task automatic run_op(input int n, input logic [4:0] o, input logic [7:0] aa, input logic [7:0] bb,
                         input logic ci, input logic ch, output logic [7:0] f, output logic c,
                         output int lat, output int gcnt);
      bit got = 1'b0;
      @(posedge clk); #1;
      v[n] = 1'b1; op[n] = o; a[n] = aa; b[n] = bb; cin[n] = ci; chain[n] = ch;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (m_acc[n]) begin got = 1'b1; break; end
      end
      v[n] = 1'b0;
      chk($sformatf("accept%0d", n), 32'(got), 32'd1);
      lat = -1; gcnt = 0; f = 8'h00; c = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (alu_G) gcnt++;
         if (r_v[n]) begin lat = k; f = r_f[n]; c = r_c[n]; break; end
      end
   endtask

   initial begin
      logic [7:0] f;
      logic       c;
      int         lat, gcnt, n_acc, pulses;
      bit         got;

      do_reset();

      // Single add on requester 0.
      run_op(0, 5'h00, 8'h0F, 8'h01, 1'b0, 1'b0, f, c, lat, gcnt);
      chk("t2_f", 32'(f), 32'h10);
      chk("t2_cout", 32'(c), 32'd0);
      chk("t2_latency", 32'(lat), 32'(LAT));
      chk("t2_g_cycles", 32'(gcnt), 32'(LAT));

      // Both requesters held valid: grants must alternate starting with 0.
      do_reset();
      gq.delete();
      cap_en = 1'b1;
      n_acc = 0;
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
         v[n] = 1'b1; op[n] = 5'h00; a[n] = 8'($urandom); b[n] = 8'($urandom);
         cin[n] = 1'b0; chain[n] = 1'b0;
      end
      for (int i = 0; i < 80 && n_acc < 4; i++) begin
         @(posedge clk); #1;
         for (int n = 0; n < 2; n++) begin
            if (m_acc[n]) begin
               n_acc++;
               a[n] = 8'($urandom); b[n] = 8'($urandom);
            end
         end
      end
      v = 2'b00;
      repeat (LAT + 2) @(negedge clk);
      cap_en = 1'b0;
      chk("t3_grant_count", 32'(gq.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t3_grant%0d", i), 32'((i < gq.size()) ? gq[i] : -1), 32'(i % 2));

      // Reset while an op is executing: no response, next op served normally.
      @(posedge clk); #1;
      v[1] = 1'b1; op[1] = 5'h00; a[1] = 8'h55; b[1] = 8'h22; cin[1] = 1'b0; chain[1] = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (m_acc[1]) begin got = 1'b1; break; end
      end
      v[1] = 1'b0;
      chk("t4_accept", 32'(got), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      repeat (LAT + 3) begin
         @(negedge clk);
         if (r_v[1]) pulses++;
      end
      chk("t4_no_rsp", 32'(pulses), 32'd0);
      run_op(1, 5'h00, 8'h03, 8'h04, 1'b0, 1'b0, f, c, lat, gcnt);
      chk("t4_f", 32'(f), 32'h07);
      chk("t4_latency", 32'(lat), 32'(LAT));

`ifdef ALU_CARRY_CHAIN_EN
      // Carry kept per requester across the other requester's op.
      do_reset();
      run_op(0, 5'h00, 8'hFF, 8'h01, 1'b0, 1'b0, f, c, lat, gcnt);
      chk("t5_f0", 32'(f), 32'h00);
      chk("t5_c0", 32'(c), 32'd1);
      run_op(1, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0, f, c, lat, gcnt);
      chk("t5_f1", 32'(f), 32'h00);
      run_op(0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b1, f, c, lat, gcnt);
      chk("t5_chain_f", 32'(f), 32'h01);
`endif

      // Random traffic; a requester keeps its request stable until accepted.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 249) == 0);
         for (int n = 0; n < 2; n++) begin
            if (!(v[n] && !m_acc[n])) begin
               v[n]     = ($urandom_range(0, 9) < 6);
               op[n]    = 5'($urandom);
               a[n]     = 8'($urandom);
               b[n]     = 8'($urandom);
               cin[n]   = 1'($urandom);
               chain[n] = 1'($urandom);
            end
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      v = 2'b00;
      repeat (LAT + 3) @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
